csr_access_unit: RTL and testbench

//  Executes Zicsr instructions (CSRRW/S/C and immediate forms) for the core; sits directly upstream of
//  the CSR block. Drives its csrReadEnable/csrWriteEnable/csrAddress/csrWriteData bus and returns
//  the old CSR value for rd. Fixed 3-cycle sequence: read, modify+write, done.

---
 rtl/csr_access_unit_if.sv | 28 ++
 rtl/csr_access_unit.sv | 161 ++++++++++++++++
 tb/tb_csr_access_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_access_unit_if.sv
// CSR block bus between the access unit (master) and the CSR register block (slave).
// Read data is combinational on csrReadEnable/csrAddress.
interface csr_access_unit_if;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    logic              csrReadEnable;
    logic              csrWriteEnable;
    logic [ADDR_W-1:0] csrAddress;
    logic [DATA_W-1:0] csrWriteData;
    logic [DATA_W-1:0] csrReadData;

    modport master (
        output csrReadEnable,
        output csrWriteEnable,
        output csrAddress,
        output csrWriteData,
        input  csrReadData
    );

    modport slave (
        input  csrReadEnable,
        input  csrWriteEnable,
        input  csrAddress,
        input  csrWriteData,
        output csrReadData
    );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr executor: fixed read / modify+write / done sequence against the CSR block,
// returning the old CSR value for rd.
module csr_access_unit #(
    parameter bit RO_CHECK = 1'b1,
    localparam int unsigned ADDR_W = 12,
    localparam int unsigned DATA_W = 32,
    localparam int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] address,
    input  logic [REG_W-1:0]  rs1Index,
    input  logic [DATA_W-1:0] rs1Data,
    input  logic [REG_W-1:0]  rdIndex,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic              rdWriteEnable,
    output logic [REG_W-1:0]  rdIndexOut,
    output logic [DATA_W-1:0] rdWriteData,
    csr_access_unit_if.master csrBus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        opQ;
    logic [ADDR_W-1:0] addressQ;
    logic [DATA_W-1:0] operandQ;
    logic [DATA_W-1:0] oldValue;
    logic              doWriteQ;
    logic              illegalQ;
    logic              readEnQ;
    logic              writeEnQ;
    logic [ADDR_W-1:0] busAddrQ;
    logic [DATA_W-1:0] writeDataQ;

    logic              accDoRead;
    logic              accDoWrite;
    logic              accIllegal;
    logic [DATA_W-1:0] accOperand;
    logic [DATA_W-1:0] readValue;
    logic [DATA_W-1:0] modValue;

    // Decode of the incoming request, used only on the accepting edge.
    always_comb begin
        accDoRead  = !(funct3[1:0] == 2'b01 && rdIndex == '0);
        accDoWrite = (funct3[1:0] == 2'b01) || (rs1Index != '0);
        accIllegal = (funct3[1:0] == 2'b00) ||
                     (RO_CHECK && (address[11:10] == 2'b11) && accDoWrite);
        accOperand = funct3[2] ? DATA_W'(rs1Index) : rs1Data;
    end

    // Read-modify value computed from the live read data during READ.
    always_comb begin
        readValue = readEnQ ? csrBus.csrReadData : '0;
        modValue  = '0;
        case (opQ)
            2'b01:   modValue = operandQ;
            2'b10:   modValue = readValue | operandQ;
            2'b11:   modValue = readValue & ~operandQ;
            default: modValue = '0;
        endcase
    end

    // A flush or reset in the WRITE cycle must kill the strobe in that same cycle.
    assign csrBus.csrReadEnable  = readEnQ;
    assign csrBus.csrWriteEnable = writeEnQ && !flush && !rst;
    assign csrBus.csrWriteData   = csrBus.csrWriteEnable ? writeDataQ : '0;
    assign csrBus.csrAddress     = busAddrQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            opQ           <= '0;
            addressQ      <= '0;
            operandQ      <= '0;
            oldValue      <= '0;
            doWriteQ      <= 1'b0;
            illegalQ      <= 1'b0;
            readEnQ       <= 1'b0;
            writeEnQ      <= 1'b0;
            busAddrQ      <= '0;
            writeDataQ    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            illegal       <= 1'b0;
            rdWriteEnable <= 1'b0;
            rdIndexOut    <= '0;
            rdWriteData   <= '0;
        end else begin
            readEnQ       <= 1'b0;
            writeEnQ      <= 1'b0;
            busAddrQ      <= '0;
            writeDataQ    <= '0;
            done          <= 1'b0;
            illegal       <= 1'b0;
            rdWriteEnable <= 1'b0;
            rdWriteData   <= '0;

            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        state      <= READ;
                        busy       <= 1'b1;
                        opQ        <= funct3[1:0];
                        addressQ   <= address;
                        operandQ   <= accOperand;
                        rdIndexOut <= rdIndex;
                        doWriteQ   <= accDoWrite;
                        illegalQ   <= accIllegal;
                        readEnQ    <= accDoRead && !accIllegal;
                        busAddrQ   <= address;
                    end
                end
                READ: begin
                    oldValue <= readValue;
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state      <= WRITE;
                        busAddrQ   <= addressQ;
                        writeEnQ   <= doWriteQ && !illegalQ;
                        writeDataQ <= (doWriteQ && !illegalQ) ? modValue : '0;
                    end
                end
                WRITE: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state         <= DONE;
                        done          <= 1'b1;
                        illegal       <= illegalQ;
                        rdWriteEnable <= !illegalQ && (rdIndexOut != '0);
                        rdWriteData   <= oldValue;
                    end
                end
                DONE: begin
                    // Write already committed, so a flush here changes nothing.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: directed spec cases, randomized ops
// against a behavioural model, flush/reset/busy corner cases.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [11:0] address;
    logic [4:0]  rs1Index;
    logic [31:0] rs1Data;
    logic [4:0]  rdIndex;
    logic        flush;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        rdWriteEnable;
    logic [4:0]  rdIndexOut;
    logic [31:0] rdWriteData;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    csr_access_unit_if csrBus ();

    csr_access_unit #(.RO_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .address(address),
        .rs1Index(rs1Index), .rs1Data(rs1Data), .rdIndex(rdIndex), .flush(flush),
        .busy(busy), .done(done), .illegal(illegal), .rdWriteEnable(rdWriteEnable),
        .rdIndexOut(rdIndexOut), .rdWriteData(rdWriteData), .csrBus(csrBus)
    );

    // CSR block model plus bus monitors
    logic [31:0] csrFile [0:4095];
    logic        pokeEn;
    logic [11:0] pokeAddr;
    logic [31:0] pokeData;
    int          readCnt  = 0;
    int          writeCnt = 0;
    int          bothHigh = 0;
    int          dataLeak = 0;
    logic [11:0] lastWrAddr = 12'h0;

    assign csrBus.csrReadData = csrBus.csrReadEnable ? csrFile[csrBus.csrAddress] : 32'h0;

    always @(posedge clk) begin
        if (pokeEn) csrFile[pokeAddr] <= pokeData;
        if (csrBus.csrWriteEnable) begin
            csrFile[csrBus.csrAddress] <= csrBus.csrWriteData;
            writeCnt   <= writeCnt + 1;
            lastWrAddr <= csrBus.csrAddress;
        end
        if (csrBus.csrReadEnable) readCnt <= readCnt + 1;
        if (csrBus.csrReadEnable && csrBus.csrWriteEnable) bothHigh <= bothHigh + 1;
        if (!csrBus.csrWriteEnable && csrBus.csrWriteData != 32'h0) dataLeak <= dataLeak + 1;
    end

    // Reference: outcome of one Zicsr op given the CSR's current value.
    function automatic void refModel(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                                     input logic [31:0] d, input logic [4:0] rd, input logic [31:0] cur,
                                     output logic eIll, output logic eRdWe, output logic [31:0] eOld,
                                     output logic [31:0] eFinal, output int eReads, output int eWrites);
        logic [31:0] opnd;
        logic [31:0] nv;
        bit          reads;
        bit          writes;
        opnd   = f3[2] ? {27'd0, r1} : d;
        reads  = !(f3[1:0] == 2'b01 && rd == 5'd0);
        writes = (f3[1:0] == 2'b01) || (r1 != 5'd0);
        eIll   = (f3[1:0] == 2'b00) || (a[11:10] == 2'b11 && writes);
        if (eIll) begin
            reads  = 1'b0;
            writes = 1'b0;
        end
        eOld = reads ? cur : 32'h0;
        case (f3[1:0])
            2'b01:   nv = opnd;
            2'b10:   nv = eOld | opnd;
            2'b11:   nv = eOld & ~opnd;
            default: nv = cur;
        endcase
        eFinal  = writes ? nv : cur;
        eRdWe   = !eIll && rd != 5'd0;
        eReads  = reads ? 1 : 0;
        eWrites = writes ? 1 : 0;
    endfunction

    // Preload the CSR, issue one op, wait (bounded) for done. lat counts edges, accept edge = 1; 0 = timeout.
    task automatic doOp(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                        input logic [31:0] d, input logic [4:0] rd, input logic [31:0] init,
                        output int lat, output logic ill, output logic rdWe,
                        output logic [31:0] rdData, output logic [4:0] rdIdx);
        @(negedge clk);
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
        funct3 = f3; address = a; rs1Index = r1; rs1Data = d; rdIndex = rd; start = 1'b1;
        pokeEn = 1'b1; pokeAddr = a; pokeData = init;
        @(posedge clk);
        #1 start = 1'b0; pokeEn = 1'b0;
        lat = 0; ill = 1'b0; rdWe = 1'b0; rdData = 32'h0; rdIdx = 5'd0;
        for (int i = 2; i <= 8 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i; ill = illegal; rdWe = rdWriteEnable; rdData = rdWriteData; rdIdx = rdIndexOut;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; funct3 = 3'b001; address = 12'h340; rs1Index = 5'd1;
        rs1Data = 32'h1; rdIndex = 5'd1; flush = 1'b0; pokeEn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nChecks++; if ({busy, done, illegal, rdWriteEnable} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {busy, done, illegal, rdWriteEnable}); else nPass++;
        nChecks++; if (rdIndexOut !== 5'd0 || rdWriteData !== 32'h0) $display("FAIL reset_rd got %0d/%h want 0/0", rdIndexOut, rdWriteData); else nPass++;
        nChecks++; if ({csrBus.csrReadEnable, csrBus.csrWriteEnable} !== 2'b0 || csrBus.csrAddress !== 12'h0 || csrBus.csrWriteData !== 32'h0)
            $display("FAIL reset_bus got re=%b we=%b a=%h d=%h want zeros", csrBus.csrReadEnable, csrBus.csrWriteEnable, csrBus.csrAddress, csrBus.csrWriteData); else nPass++;
        start = 1'b0;
        @(negedge clk) rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0] f3; logic [11:0] a; logic [4:0] r1; logic [31:0] d; logic [4:0] rd; logic [31:0] init;
        logic ill; logic rdWe; logic [31:0] rdData; logic [31:0] fin; int nr; int nw;
    } dirCase_t;

    task automatic test_directed();
        dirCase_t c [8];
        int lat; logic ill, rdWe; logic [31:0] rdData; logic [4:0] rdIdx; int r0, w0;
        c[0] = '{3'b001, 12'h340, 5'd1, 32'hDEADBEEF, 5'd5, 32'h12, 1'b0, 1'b1, 32'h12, 32'hDEADBEEF, 1, 1};
        c[1] = '{3'b010, 12'h300, 5'd2, 32'h000000F0, 5'd3, 32'h0F, 1'b0, 1'b1, 32'h0F, 32'hFF, 1, 1};
        c[2] = '{3'b111, 12'h300, 5'd3, 32'hFFFFFFFF, 5'd4, 32'hFF, 1'b0, 1'b1, 32'hFF, 32'hFC, 1, 1};
        c[3] = '{3'b010, 12'hC00, 5'd0, 32'hFFFFFFFF, 5'd6, 32'h55, 1'b0, 1'b1, 32'h55, 32'h55, 1, 0};
        c[4] = '{3'b001, 12'hC00, 5'd1, 32'h00000001, 5'd7, 32'h55, 1'b1, 1'b0, 32'h0, 32'h55, 0, 0};
        c[5] = '{3'b001, 12'h340, 5'd1, 32'h0000A5A5, 5'd0, 32'h77, 1'b0, 1'b0, 32'h0, 32'hA5A5, 0, 1};
        c[6] = '{3'b100, 12'h340, 5'd1, 32'h12345678, 5'd5, 32'h77, 1'b1, 1'b0, 32'h0, 32'h77, 0, 0};
        c[7] = '{3'b101, 12'h340, 5'd31, 32'hFFFFFFFF, 5'd2, 32'h9, 1'b0, 1'b1, 32'h9, 32'h1F, 1, 1};
        for (int i = 0; i < 8; i++) begin
            r0 = readCnt; w0 = writeCnt;
            doOp(c[i].f3, c[i].a, c[i].r1, c[i].d, c[i].rd, c[i].init, lat, ill, rdWe, rdData, rdIdx);
            nChecks++; if (lat !== 3) $display("FAIL dir%0d_latency got %0d want 3", i, lat); else nPass++;
            nChecks++; if (ill !== c[i].ill || rdWe !== c[i].rdWe) $display("FAIL dir%0d_flags got ill=%b rdWe=%b want ill=%b rdWe=%b", i, ill, rdWe, c[i].ill, c[i].rdWe); else nPass++;
            nChecks++; if (rdData !== c[i].rdData || rdIdx !== c[i].rd) $display("FAIL dir%0d_rd got %h/x%0d want %h/x%0d", i, rdData, rdIdx, c[i].rdData, c[i].rd); else nPass++;
            nChecks++; if (csrFile[c[i].a] !== c[i].fin) $display("FAIL dir%0d_csr got %h want %h", i, csrFile[c[i].a], c[i].fin); else nPass++;
            nChecks++; if (readCnt - r0 !== c[i].nr || writeCnt - w0 !== c[i].nw) $display("FAIL dir%0d_access got r=%0d w=%0d want r=%0d w=%0d", i, readCnt - r0, writeCnt - w0, c[i].nr, c[i].nw); else nPass++;
        end
    endtask

    task automatic test_random();
        logic [11:0] addrs [6];
        logic [2:0] f3; logic [11:0] a; logic [4:0] r1, rd; logic [31:0] d, init;
        logic eIll, eRdWe; logic [31:0] eOld, eFin; int eR, eW;
        int lat; logic ill, rdWe; logic [31:0] rdData; logic [4:0] rdIdx; int r0, w0;
        addrs[0] = 12'h340; addrs[1] = 12'h300; addrs[2] = 12'hC00;
        addrs[3] = 12'hC81; addrs[4] = 12'h7C0; addrs[5] = 12'hF14;
        for (int i = 0; i < 60; i++) begin
            f3   = 3'($urandom_range(0, 7));
            a    = addrs[$urandom_range(0, 5)];
            r1   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            d    = $urandom;
            init = $urandom;
            refModel(f3, a, r1, d, rd, init, eIll, eRdWe, eOld, eFin, eR, eW);
            r0 = readCnt; w0 = writeCnt;
            doOp(f3, a, r1, d, rd, init, lat, ill, rdWe, rdData, rdIdx);
            nChecks++; if (lat !== 3) $display("FAIL rnd%0d_latency got %0d want 3", i, lat); else nPass++;
            nChecks++; if (ill !== eIll || rdWe !== eRdWe) $display("FAIL rnd%0d_flags f3=%b a=%h got ill=%b rdWe=%b want %b/%b", i, f3, a, ill, rdWe, eIll, eRdWe); else nPass++;
            nChecks++; if (rdData !== eOld || rdIdx !== rd) $display("FAIL rnd%0d_rd got %h/x%0d want %h/x%0d", i, rdData, rdIdx, eOld, rd); else nPass++;
            nChecks++; if (csrFile[a] !== eFin) $display("FAIL rnd%0d_csr f3=%b got %h want %h", i, f3, csrFile[a], eFin); else nPass++;
            nChecks++; if (readCnt - r0 !== eR || writeCnt - w0 !== eW) $display("FAIL rnd%0d_access got r=%0d w=%0d want r=%0d w=%0d", i, readCnt - r0, writeCnt - w0, eR, eW); else nPass++;
            if (eW == 1) begin
                nChecks++; if (lastWrAddr !== a) $display("FAIL rnd%0d_wraddr got %h want %h", i, lastWrAddr, a); else nPass++;
            end
        end
    endtask

    // Launch a CSRRW to 0x340 that would write; returns just after the accepting edge (READ cycle).
    task automatic launchRw(input logic [31:0] init, input logic [31:0] d);
        @(negedge clk);
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
        funct3 = 3'b001; address = 12'h340; rs1Index = 5'd1; rs1Data = d; rdIndex = 5'd5; start = 1'b1;
        pokeEn = 1'b1; pokeAddr = 12'h340; pokeData = init;
        @(posedge clk);
        #1 start = 1'b0; pokeEn = 1'b0;
    endtask

    task automatic test_flush();
        int w0, dones;
        // flush in WRITE
        w0 = writeCnt; dones = 0;
        launchRw(32'h33, 32'h11112222);
        @(posedge clk); #1 flush = 1'b1;
        #1;
        nChecks++; if (csrBus.csrWriteEnable !== 1'b0 || csrBus.csrWriteData !== 32'h0) $display("FAIL flushW_strobe got we=%b d=%h want 0/0", csrBus.csrWriteEnable, csrBus.csrWriteData); else nPass++;
        @(posedge clk); #1 flush = 1'b0;
        nChecks++; if (busy !== 1'b0) $display("FAIL flushW_idle got busy=%b want 0", busy); else nPass++;
        if (done) dones++;
        repeat (4) begin @(posedge clk); #1; if (done) dones++; end
        nChecks++; if (dones !== 0 || writeCnt !== w0 || csrFile[12'h340] !== 32'h33) $display("FAIL flushW_effect got dones=%0d writes=%0d csr=%h want 0/0/33", dones, writeCnt - w0, csrFile[12'h340]); else nPass++;
        // flush in READ
        w0 = writeCnt; dones = 0;
        launchRw(32'h44, 32'h5555);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        nChecks++; if (busy !== 1'b0 || csrBus.csrAddress !== 12'h0) $display("FAIL flushR_idle got busy=%b addr=%h want 0/0", busy, csrBus.csrAddress); else nPass++;
        repeat (4) begin @(posedge clk); #1; if (done) dones++; end
        nChecks++; if (dones !== 0 || writeCnt !== w0) $display("FAIL flushR_effect got dones=%0d writes=%0d want 0/0", dones, writeCnt - w0); else nPass++;
        // flush in DONE: completes anyway
        w0 = writeCnt;
        launchRw(32'h66, 32'h7777);
        @(posedge clk); @(posedge clk); #1 flush = 1'b1;
        nChecks++; if (done !== 1'b1 || rdWriteData !== 32'h66 || csrFile[12'h340] !== 32'h7777) $display("FAIL flushD_done got done=%b rd=%h csr=%h want 1/66/7777", done, rdWriteData, csrFile[12'h340]); else nPass++;
        @(posedge clk); #1 flush = 1'b0;
        nChecks++; if (busy !== 1'b0 || writeCnt - w0 !== 1) $display("FAIL flushD_idle got busy=%b writes=%0d want 0/1", busy, writeCnt - w0); else nPass++;
        // flush + start in IDLE
        @(negedge clk); start = 1'b1; flush = 1'b1;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        nChecks++; if (busy !== 1'b0 || csrBus.csrReadEnable !== 1'b0) $display("FAIL flushIdle_start got busy=%b re=%b want 0/0", busy, csrBus.csrReadEnable); else nPass++;
    endtask

    task automatic test_back_to_back();
        int w0, dones, lat;
        @(negedge clk); pokeEn = 1'b1; pokeAddr = 12'h300; pokeData = 32'hABCD;
        @(posedge clk); #1 pokeEn = 1'b0;
        w0 = writeCnt; dones = 0; lat = 0;
        launchRw(32'h10, 32'h2020);
        funct3 = 3'b001; address = 12'h300; rs1Index = 5'd2; rs1Data = 32'h9999; start = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 3) start = 1'b0;
            if (done) begin dones++; lat = i; end
        end
        nChecks++; if (dones !== 1 || lat !== 3) $display("FAIL busyStart_done got dones=%0d lat=%0d want 1/3", dones, lat); else nPass++;
        nChecks++; if (csrFile[12'h300] !== 32'hABCD || csrFile[12'h340] !== 32'h2020 || writeCnt - w0 !== 1)
            $display("FAIL busyStart_csr got 300=%h 340=%h writes=%0d want ABCD/2020/1", csrFile[12'h300], csrFile[12'h340], writeCnt - w0); else nPass++;
    endtask

    task automatic test_rst_mid();
        int w0, lat; logic ill, rdWe; logic [31:0] rdData; logic [4:0] rdIdx;
        w0 = writeCnt;
        launchRw(32'h21, 32'hCAFE);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        nChecks++; if ({busy, done, illegal, rdWriteEnable, csrBus.csrReadEnable, csrBus.csrWriteEnable} !== 6'b0 || rdIndexOut !== 5'd0 || csrBus.csrAddress !== 12'h0)
            $display("FAIL rstMid_outputs got busy=%b done=%b re=%b we=%b rdIdx=%0d addr=%h want zeros", busy, done, csrBus.csrReadEnable, csrBus.csrWriteEnable, rdIndexOut, csrBus.csrAddress); else nPass++;
        repeat (3) @(posedge clk); #1;
        nChecks++; if (writeCnt !== w0 || csrFile[12'h340] !== 32'h21) $display("FAIL rstMid_nowrite got writes=%0d csr=%h want 0/21", writeCnt - w0, csrFile[12'h340]); else nPass++;
        doOp(3'b010, 12'h340, 5'd4, 32'h100, 5'd9, 32'h21, lat, ill, rdWe, rdData, rdIdx);
        nChecks++; if (lat !== 3 || rdData !== 32'h21 || csrFile[12'h340] !== 32'h121) $display("FAIL rstMid_after got lat=%0d rd=%h csr=%h want 3/21/121", lat, rdData, csrFile[12'h340]); else nPass++;
    endtask

    task automatic test_bus_invariants();
        nChecks++; if (bothHigh !== 0) $display("FAIL bus_both_enables got %0d cycles want 0", bothHigh); else nPass++;
        nChecks++; if (dataLeak !== 0) $display("FAIL bus_data_when_idle got %0d cycles want 0", dataLeak); else nPass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_rst_mid();
        test_bus_invariants();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, passed %0d of %0d", nPass, nChecks);
        $fatal(1);
    end

endmodule
